// File: rtl/dmem_mmio_responder.sv
// Data-memory bus responder: 16-word MMIO window (scratch, cycle counter, byte TX FIFO), dmem passthrough elsewhere.
// Define MMIO_FIFO_BYPASS_EN to let a TXDATA store reach an idle, ready consumer in the same cycle.
module dmem_mmio_responder #(
   parameter logic [11:0] MMIO_BASE  = 12'hFF0,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CNT_WIDTH  = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic [31:0] q_dmem,
   output logic        dmem_wren,
   output logic [31:0] q_out,
   output logic        mmio_hit,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [3:0] OFF_SCRATCH = 4'd0;
   localparam logic [3:0] OFF_CYCLES  = 4'd1;
   localparam logic [3:0] OFF_TXDATA  = 4'd2;
   localparam logic [3:0] OFF_STATUS  = 4'd3;
   localparam logic [3:0] OFF_CTRL    = 4'd4;

   logic [31:0]          scratch_q, scratch_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 tx_en_q, tx_en_d;
   logic                 ovf_q, ovf_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 hit_q, hit_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [7:0]           fifo_mem_q [FIFO_DEPTH];

   logic       hit, wr_hit, fifo_empty, fifo_full, fifo_valid;
   logic       pop, push_req, push, bypass;
   logic [3:0] offset;

   assign hit       = (address_dmem[11:4] == MMIO_BASE[11:4]);
   assign offset    = address_dmem[3:0];
   assign mmio_hit  = hit;
   assign dmem_wren = wren & ~hit;
   assign q_out     = hit_q ? rdata_q : q_dmem;

   assign wr_hit     = wren & hit;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_valid = tx_en_q & ~fifo_empty;
   assign pop        = fifo_valid & out_ready;
   assign push_req   = wr_hit & (offset == OFF_TXDATA);

`ifdef MMIO_FIFO_BYPASS_EN
   assign bypass    = push_req & tx_en_q & fifo_empty & out_ready;
   assign out_valid = fifo_valid | bypass;
   assign out_data  = bypass ? data[7:0] : fifo_mem_q[rd_ptr_q];
`else
   assign bypass    = 1'b0;
   assign out_valid = fifo_valid;
   assign out_data  = fifo_mem_q[rd_ptr_q];
`endif

   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push = push_req & ~bypass & (~fifo_full | pop);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      scratch_d = scratch_q;
      tx_en_d   = tx_en_q;
      ovf_d     = ovf_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      cnt_d     = cnt_q + CNT_WIDTH'(1);
      hit_d     = hit;
      rdata_d   = 32'h0;

      if (wr_hit) begin
         case (offset)
            OFF_SCRATCH: scratch_d = data;
            OFF_CYCLES:  cnt_d     = '0;
            OFF_STATUS:  ovf_d     = 1'b0;
            OFF_CTRL:    tx_en_d   = data[0];
            default: ;
         endcase
      end
      if (push_req & ~bypass & fifo_full & ~pop)
         ovf_d = 1'b1;

      // Count occupies bits 15:8 of STATUS.
      case (offset)
         OFF_SCRATCH: rdata_d = scratch_q;
         OFF_CYCLES:  rdata_d = 32'(cnt_q);
         OFF_STATUS:  rdata_d = {16'h0, 8'(count_q), 5'b0, ovf_q, fifo_empty, fifo_full};
         OFF_CTRL:    rdata_d = {31'h0, tx_en_q};
         default:     rdata_d = 32'h0;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scratch_q <= '0;
         cnt_q     <= '0;
         tx_en_q   <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         hit_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         tx_en_q   <= tx_en_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         hit_q     <= hit_d;
         rdata_q   <= rdata_d;
      end
   end

   // NOTE: FIFO storage is not reset; pointers and count alone decide which entries are live.
   always_ff @(posedge clock) begin
      if (push)
         fifo_mem_q[wr_ptr_q] <= data[7:0];
   end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: queue scoreboard fed by a behavioural model,
// with a second instance at CNT_WIDTH=4 to observe counter wrap.
module tb_dmem_mmio_responder;
   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] address_dmem = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] q_dmem = '0;
   logic        dmem_wren, mmio_hit, out_valid;
   logic [31:0] q_out;
   logic [7:0]  out_data;
   logic        c4_dmem_wren, c4_mmio_hit, c4_out_valid;
   logic [31:0] c4_q_out;
   logic [7:0]  c4_out_data;

   int checks = 0;
   int errors = 0;

   dmem_mmio_responder dut (
      .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
      .q_dmem(q_dmem), .dmem_wren(dmem_wren), .q_out(q_out), .mmio_hit(mmio_hit),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   dmem_mmio_responder #(.CNT_WIDTH(4)) dut_c4 (
      .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
      .q_dmem(q_dmem), .dmem_wren(c4_dmem_wren), .q_out(c4_q_out), .mmio_hit(c4_mmio_hit),
      .out_data(c4_out_data), .out_valid(c4_out_valid), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   // Environment syncram driven by the DUT's gated write enable.
   bit [31:0] sram [4096];
   always @(posedge clock) begin
      if (dmem_wren) sram[address_dmem] <= data;
      q_dmem <= sram[address_dmem];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, stated in terms of the register map and a byte queue.
   typedef struct packed {logic [31:0] e32; logic [31:0] e4;} rd_t;
   logic [31:0] m_scratch = '0;
   int unsigned m_cyc = 0;
   logic        m_tx_en = 1'b0;
   logic        m_ovf = 1'b0;
   logic [7:0]  m_fifo [$];
   logic [7:0]  tx_exp [$];
   rd_t         rd_exp [$];
   logic        rd_due = 1'b0;
   bit [31:0]   ref_mem [4096];

   function automatic rd_t model_read(input logic [11:0] a);
      rd_t r;
      r.e32 = 32'h0;
      if (a[11:4] != 8'hFF) r.e32 = ref_mem[a];
      else begin
         case (a[3:0])
            4'd0: r.e32 = m_scratch;
            4'd1: r.e32 = m_cyc;
            4'd3: r.e32 = {16'h0, 8'(m_fifo.size()), 5'b0, m_ovf,
                           m_fifo.size() == 0, m_fifo.size() == DEPTH};
            4'd4: r.e32 = {31'h0, m_tx_en};
            default: r.e32 = 32'h0;
         endcase
      end
      r.e4 = (a == 12'hFF1) ? (m_cyc % 16) : r.e32;
      return r;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_scratch = '0; m_cyc = 0; m_tx_en = 1'b0; m_ovf = 1'b0; rd_due = 1'b0;
         m_fifo.delete(); tx_exp.delete(); rd_exp.delete();
      end else begin
         bit hit, pop, push_req, bypass, full_pre;
         logic [3:0] off;
         hit = (address_dmem[11:4] == 8'hFF);
         off = address_dmem[3:0];
         rd_due = !wren;
         if (!wren) rd_exp.push_back(model_read(address_dmem));
         full_pre = (m_fifo.size() == DEPTH);
         pop = m_tx_en && (m_fifo.size() != 0) && out_ready;
         push_req = hit && wren && (off == 4'd2);
         bypass = 1'b0;
`ifdef MMIO_FIFO_BYPASS_EN
         bypass = push_req && m_tx_en && (m_fifo.size() == 0) && out_ready;
`endif
         if (pop) m_fifo.delete(0);
         if (push_req && !bypass) begin
            if (!full_pre || pop) begin
               m_fifo.push_back(data[7:0]);
               tx_exp.push_back(data[7:0]);
            end else m_ovf = 1'b1;
         end
         if (hit && wren && off == 4'd1) m_cyc = 0;
         else m_cyc++;
         if (hit && wren) begin
            case (off)
               4'd0: m_scratch = data;
               4'd3: m_ovf = 1'b0;
               4'd4: m_tx_en = data[0];
               default: ;
            endcase
         end
         if (wren && !hit) ref_mem[address_dmem] = data;
      end
   end

   // Monitor: compares whatever the DUT presents mid-cycle against the scoreboard.
   always @(negedge clock) begin
      if (reset) begin
         bit bypass_now;
         rd_t r;
         logic [7:0] eb;
         check("dmem_wren", dmem_wren, wren && (address_dmem[11:4] != 8'hFF));
         check("mmio_hit", mmio_hit, address_dmem[11:4] == 8'hFF);
         bypass_now = 1'b0;
`ifdef MMIO_FIFO_BYPASS_EN
         bypass_now = wren && (address_dmem == 12'hFF2) && out_ready && m_tx_en && (m_fifo.size() == 0);
`endif
         check("out_valid", out_valid, m_tx_en && (m_fifo.size() != 0 || bypass_now));
         if (rd_due) begin
            checks++;
            if (rd_exp.size() == 0) begin
               errors++;
               $display("FAIL q_out: response due but none expected at %0t", $time);
            end else begin
               r = rd_exp.pop_front();
               check("q_out", q_out, r.e32);
               check("q_out_cnt4", c4_q_out, r.e4);
            end
         end
         if (out_valid && out_ready) begin
            if (bypass_now) check("out_data_bypass", out_data, data[7:0]);
            else if (tx_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_data: handshake %h with no byte expected at %0t", out_data, $time);
            end else begin
               eb = tx_exp.pop_front();
               check("out_data", out_data, eb);
            end
         end
      end
   end

   task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
      address_dmem = a; data = d; wren = w; out_ready = r;
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] a;
      #2;
      check("rst_q_out", q_out, q_dmem);
      check("rst_out_valid", out_valid, 1'b0);
      address_dmem = 12'hFF3; wren = 1'b1; #1;
      check("rst_mmio_hit", mmio_hit, 1'b1);
      check("rst_dmem_wren_hit", dmem_wren, 1'b0);
      address_dmem = 12'h010; #1;
      check("rst_mmio_miss", mmio_hit, 1'b0);
      check("rst_dmem_wren_miss", dmem_wren, 1'b1);
      wren = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;

      step(12'hFF0, 32'hDEADBEEF, 1, 0);
      step(12'hFF0, 32'h0, 0, 0);
      step(12'h010, 32'h12345678, 1, 0);
      step(12'h010, 32'h0, 0, 0);

      for (int i = 1; i <= 9; i++) step(12'hFF2, 32'(i), 1, 0);
      step(12'hFF3, 32'h0, 0, 0);
      step(12'hFF4, 32'h1, 1, 1);
      for (int i = 0; i < 10; i++) step(12'h020, 32'h0, 0, 1);
      step(12'hFF3, 32'h0, 1, 0);
      step(12'hFF3, 32'h0, 0, 0);

      step(12'hFF4, 32'h0, 1, 0);
      for (int i = 0; i < DEPTH; i++) step(12'hFF2, 32'h10 + 32'(i), 1, 0);
      step(12'hFF4, 32'h1, 1, 0);
      step(12'hFF2, 32'hAA, 1, 1);
      step(12'hFF3, 32'h0, 0, 0);
      for (int i = 0; i < 10; i++) step(12'h021, 32'h0, 0, 1);

      step(12'hFF1, 32'h5, 1, 0);
      step(12'h030, 32'h0, 0, 0);
      step(12'h030, 32'h0, 0, 0);
      step(12'hFF1, 32'h0, 0, 0);
      step(12'hFF1, 32'h0, 1, 0);
      for (int i = 0; i < 15; i++) step(12'h031, 32'h0, 0, 0);
      step(12'hFF1, 32'h0, 0, 0);

      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5:
               a = 12'hFF0 | 12'(($urandom_range(0, 3) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 4));
            6, 7: a = 12'(  $urandom_range(0, 7));
            8:    a = 12'hFEF;
            default: a = 12'hFFF;
         endcase
         step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      step(12'hFF4, 32'h1, 1, 0);
      step(12'hFF0, 32'hCAFEF00D, 1, 0);
      for (int i = 0; i < 3; i++) step(12'hFF2, 32'h40 + 32'(i), 1, 0);
      step(12'hFF0, 32'h0, 0, 0);
      address_dmem = 12'h020; wren = 1'b0; out_ready = 1'b0;
      #3 reset = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_q_out", q_out, q_dmem);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;
      step(12'hFF0, 32'h0, 0, 0);
      step(12'hFF3, 32'h0, 0, 0);
      step(12'h020, 32'h0, 0, 1);
      @(negedge clock); #1;
      check("dmem_window_untouched", sram[12'hFF0], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
